// File: rtl/share_target_check.sv
// Share qualification for double-SHA256 digests: expands nBits, compares the
// byte-reversed digest against the target one 32-bit word per cycle, queues share nonces.
module share_target_check #(
   parameter int FIFO_DEPTH = 4,
   parameter int DROP_W     = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [255:0]      hash_in,
   input  logic [31:0]       nonce_in,
   input  logic [31:0]       bits_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [31:0]       share_nonce,
   output logic              share_valid,
   input  logic              share_ready,
   output logic [31:0]       hash_count,
   output logic [31:0]       share_count,
   output logic [DROP_W-1:0] drop_count,
   output logic              busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, EXPAND, COMPARE, RESULT} state_t;

   state_t         state;
   logic [255:0]   v_reg;
   logic [255:0]   t_reg;
   logic [31:0]    nonce_reg;
   logic [31:0]    bits_reg;
   logic [2:0]     idx;
   logic           lt;
   logic [31:0]    word_v;
   logic [31:0]    word_t;

   logic [31:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic           full;
   logic           push;
   logic           pop;

   function automatic logic [255:0] byte_rev(input logic [255:0] h);
      logic [255:0] r;
      r = '0;
      for (int b = 0; b < 32; b++) begin
         r[8*b +: 8] = h[255-8*b -: 8];
      end
      return r;
   endfunction

   // Negative or zero mantissa yields a zero target so nothing can qualify.
   function automatic logic [255:0] expand_target(input logic [31:0] bits);
      logic [255:0] mant;
      logic [7:0]   expo;
      mant = {232'd0, bits[23:0]};
      expo = bits[31:24];
      if (bits[23] || (bits[23:0] == 24'd0)) return '0;
      if (expo <= 8'd3) return mant >> (8 * (3 - int'(expo)));
      return mant << (8 * (int'(expo) - 3));
   endfunction

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] x);
      return (&x) ? x : x + 1'b1;
   endfunction

   assign word_v = v_reg[{idx, 5'd0} +: 32];
   assign word_t = t_reg[{idx, 5'd0} +: 32];

   assign full        = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign share_valid = (count != '0);
   assign pop         = share_valid & share_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
   assign push        = (state == RESULT) & lt & (~full | pop);
   assign share_nonce = share_valid ? mem[rd_ptr] : 32'd0;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state       <= IDLE;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         idx         <= 3'd7;
         lt          <= 1'b0;
         hash_count  <= '0;
         share_count <= '0;
         drop_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  v_reg     <= byte_rev(hash_in);
                  nonce_reg <= nonce_in;
                  bits_reg  <= bits_in;
                  state     <= EXPAND;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
               end else begin
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            EXPAND: begin
               t_reg <= expand_target(bits_reg);
               idx   <= 3'd7;
               state <= COMPARE;
            end
            COMPARE: begin
               if (word_v < word_t) begin
                  lt    <= 1'b1;
                  state <= RESULT;
               end else if (word_v > word_t || idx == 3'd0) begin
                  lt    <= 1'b0;
                  state <= RESULT;
               end else begin
                  idx <= idx - 3'd1;
               end
            end
            RESULT: begin
               hash_count <= hash_count + 32'd1;
               if (lt) begin
                  share_count <= share_count + 32'd1;
                  if (full && !pop) drop_count <= sat_inc(drop_count);
               end
               state    <= IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= nonce_reg;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_share_target_check.sv
// Randomized bench for share_target_check against an arithmetic reference
// model (little-endian digest value, target by powers of 256, queue FIFO).
module tb_share_target_check;

   localparam int DEPTH = 4;

   logic         clock = 1'b0;
   logic         resetn;
   logic [255:0] hash_in;
   logic [31:0]  nonce_in;
   logic [31:0]  bits_in;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  share_nonce;
   logic         share_valid;
   logic         share_ready;
   logic [31:0]  hash_count;
   logic [31:0]  share_count;
   logic [15:0]  drop_count;
   logic         busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] q[$];
   int          m_hash;
   int          m_share;
   int          m_drop;
   logic [31:0] cur_nonce;
   bit          rand_ready = 0;
   bit          ready_at_result = 0;

   share_target_check #(.FIFO_DEPTH(DEPTH), .DROP_W(16)) dut (
      .clock(clock), .resetn(resetn), .hash_in(hash_in), .nonce_in(nonce_in),
      .bits_in(bits_in), .in_valid(in_valid), .in_ready(in_ready),
      .share_nonce(share_nonce), .share_valid(share_valid), .share_ready(share_ready),
      .hash_count(hash_count), .share_count(share_count), .drop_count(drop_count),
      .busy(busy)
   );

   always #5 clock = ~clock;

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Digest byte 0 is the least significant byte of the value under test.
   function automatic logic [255:0] ref_value(input logic [255:0] h);
      logic [255:0] v;
      v = '0;
      for (int b = 31; b >= 0; b--) v = v * 256 + h[255-8*b -: 8];
      return v;
   endfunction

   function automatic logic [255:0] mk_hash(input logic [255:0] v);
      logic [255:0] h;
      h = '0;
      for (int b = 0; b < 32; b++) h[255-8*b -: 8] = v[8*b +: 8];
      return h;
   endfunction

   function automatic logic [255:0] ref_target(input logic [31:0] b);
      logic [255:0] t;
      int e;
      e = int'(b[31:24]);
      if (b[23] == 1'b1 || b[23:0] == 24'd0) return '0;
      t = 256'(b[23:0]);
      if (e < 3) for (int i = 0; i < 3 - e; i++) t = t / 256;
      else       for (int i = 0; i < e - 3; i++) t = t * 256;
      return t;
   endfunction

   function automatic int ref_words(input logic [255:0] v, input logic [255:0] t);
      for (int w = 7; w >= 0; w--) if (v[32*w +: 32] != t[32*w +: 32]) return 8 - w;
      return 8;
   endfunction

   task automatic tick(input bit result_now, input bit is_share);
      bit pop;
      if (rand_ready) share_ready = 1'($urandom_range(0, 1));
      pop = share_ready && (q.size() > 0);
      check("share_valid", share_valid, q.size() > 0);
      if (pop) check("share_nonce", share_nonce, q[0]);
      @(posedge clock);
      if (pop) q.delete(0);
      if (result_now) begin
         m_hash++;
         if (is_share) begin
            m_share++;
            if (q.size() < DEPTH) q.push_back(cur_nonce);
            else if (m_drop < 65535) m_drop++;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      q.delete();
      m_hash = 0; m_share = 0; m_drop = 0;
      check("rst_in_ready", in_ready, 0);
      check("rst_share_valid", share_valid, 0);
      check("rst_share_nonce", share_nonce, 0);
      check("rst_busy", busy, 0);
      check("rst_counts", {hash_count, share_count}, 0);
      check("rst_drop", drop_count, 0);
      resetn = 1'b1;
      @(posedge clock);
      #1;
      check("rst_release_in_ready", in_ready, 1);
   endtask

   task automatic send(input logic [255:0] h, input logic [31:0] n, input logic [31:0] b);
      logic [255:0] v, t;
      int k, waitc;
      bit sh;
      v = ref_value(h);
      t = ref_target(b);
      sh = (v < t);
      k = ref_words(v, t);
      waitc = 0;
      while (!in_ready && waitc < 20) begin
         tick(0, 0);
         waitc++;
      end
      check("accept_ready", in_ready, 1);
      hash_in = h; nonce_in = n; bits_in = b; in_valid = 1'b1; cur_nonce = n;
      tick(0, 0);
      for (int c = 1; c <= 2 + k; c++) begin
         if (c <= 1 + k) begin
            in_valid = 1'($urandom_range(0, 1));
            hash_in  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            nonce_in = $urandom;
            bits_in  = $urandom;
         end else begin
            in_valid = 1'b0;
            if (ready_at_result) share_ready = 1'b1;
         end
         tick(c == 2 + k, sh);
         if (c == 1)     check("busy_in_ready", in_ready, 0);
         if (c == 1 + k) check("busy_before_result", busy, 1);
      end
      check("in_ready_after", in_ready, 1);
      check("busy_after", busy, 0);
      check("hash_count", hash_count, 32'(m_hash));
      check("share_count", share_count, 32'(m_share));
      check("drop_count", drop_count, 16'(m_drop));
   endtask

   task automatic drain();
      int c;
      c = 0;
      share_ready = 1'b1;
      while (q.size() > 0 && c < 20) begin
         tick(0, 0);
         c++;
      end
      check("drain_empty", share_valid, 0);
      share_ready = 1'b0;
   endtask

   initial begin
      logic [255:0] t, v;
      logic [31:0]  b;
      resetn = 1'b0; in_valid = 1'b0; share_ready = 1'b0;
      hash_in = '0; nonce_in = '0; bits_in = '0;
      do_reset();

      send('0, 32'h42A14695, 32'h1d00ffff);
      check("t1_nonce", share_nonce, 32'h42A14695);
      drain();
      send('1, 32'h1, 32'h1d00ffff);

      t = ref_target(32'h1d00ffff);
      send(mk_hash(t), 32'h2, 32'h1d00ffff);
      send(mk_hash(t - 1), 32'h3, 32'h1d00ffff);
      drain();
      send('0, 32'h4, 32'h1d80ffff);
      send('0, 32'h5, 32'h03000000);
      check("no_share_neg_zero", share_valid, 0);

      do_reset();
      for (int i = 0; i < 6; i++) send('0, 32'h100 + i, 32'h1d00ffff);
      check("fifo_full_drop", drop_count, 2);
      ready_at_result = 1'b1;
      send('0, 32'h777, 32'h1d00ffff);
      ready_at_result = 1'b0;
      share_ready = 1'b0;
      drain();

      do_reset();
      hash_in = mk_hash(t); nonce_in = 32'h9; bits_in = 32'h1d00ffff; in_valid = 1'b1;
      tick(0, 0);
      in_valid = 1'b0;
      tick(0, 0); tick(0, 0); tick(0, 0);
      check("abort_in_compare", busy, 1);
      do_reset();
      repeat (12) tick(0, 0);
      check("abort_hash_count", hash_count, 0);
      check("abort_share_count", share_count, 0);

      rand_ready = 1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 7) == 0) b = $urandom;
         else b = {8'($urandom_range(1, 32)), 1'b0, 23'($urandom_range(1, 32'h7fffff))};
         t = ref_target(b);
         case ($urandom_range(0, 3))
            0: v = t - 256'(1 + $urandom_range(0, 3));
            1: v = t + 256'($urandom_range(0, 3));
            2: v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 255);
            default: v = t ^ (256'(1) << $urandom_range(0, 255));
         endcase
         send(mk_hash(v), $urandom, b);
      end
      rand_ready = 0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
